inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Producer side of the decoder's instruction interface. Reads opcode and operand bytes
//  from byte-wide memory and pre-decodes the length (1..3).
//  Presents one complete instruction (opcode, operands, len, pc) per valid/ready handshake.
//  Takes PC redirects from the branch/execute stage. After reset it loads the start PC from the 6502 reset vector.
// PARAMETERS
//  VEC_ADDR   16'hFFFC  address of reset-vector low byte (high byte at VEC_ADDR+1)
//  USE_VECTOR 1         1: fetch start PC from vector; 0: start directly at VEC_ADDR
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   synchronous reset, active low
//  mem_req        out  1   memory read request
//  mem_addr       out  16  read address, stable while mem_req=1
//  mem_ack        in   1   read complete; mem_rdata valid this cycle
//  mem_rdata      in   8   read data
//  redirect_valid in   1   flush and restart fetch at redirect_pc
//  redirect_pc    in   16  new fetch PC
//  inst_valid     out  1   instruction bundle valid
//  inst_ready     in   1   decoder accepts bundle
//  inst_opcode    out  8   opcode byte
//  inst_op1       out  8   first operand byte (0 if len<2)
//  inst_op2       out  8   second operand byte (0 if len<3)
//  inst_len       out  2   instruction length, 1..3
//  inst_pc        out  16  address of opcode byte
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all outputs 0, drop flag cleared.
//   USE_VECTOR=1: state VEC_LO, pc=VEC_ADDR. USE_VECTOR=0: state OPC, pc=VEC_ADDR.
//  States: VEC_LO -> VEC_HI -> OPC -> OP1 -> OP2 -> HOLD -> OPC.
//   OP1 and OP2 are skipped per length.
//   VEC_LO/VEC_HI: read VEC_ADDR/VEC_ADDR+1; pc={hi,lo} on VEC_HI ack.
//   OPC: read pc; on ack latch opcode, inst_pc=pc, compute len, pc+=1; go to OP1 (len>1) or HOLD.
//   OP1/OP2: read pc; on ack latch byte, pc+=1; continue per len.
//   HOLD: inst_valid=1, bundle stable; on inst_ready go to OPC, and mem_req may assert the same cycle.
//  Memory handshake: mem_req/mem_addr held until the mem_ack cycle.
//   At most one request is outstanding. mem_req may drop in the cycle after ack.
//   Zero-wait memory (ack same cycle as req) gives 1 byte/cycle.
//  Latency: len-N instruction has inst_valid N cycles after first OPC request, at zero wait.
//  PC arithmetic is 16-bit modulo: FFFF+1 wraps to 0000.
//  Length pre-decode on opcode o, cc=o[1:0], bbb=o[4:2], first match wins:
//   o=20 -> 3; o in {00,40,60} -> 1; o[4:0]=10000 (branch) -> 2;
//   o[3:0]=1000 -> 1; o[7]=1 and o[3:0]=1010 -> 1;
//   cc=01: bbb in {011,110,111} -> 3, else 2;
//   cc=00/10: bbb 000,001,101 -> 2; 011,111 -> 3; 010,100,110 -> 1;
//   cc=11 (undefined) -> 1.
//  Redirect (highest priority, any state except reset/vector states):
//   next cycle: inst_valid=0, pc=redirect_pc, state OPC.
//   A HOLD bundle with inst_ready=1 in the redirect cycle counts as accepted.
//   If a request is outstanding (mem_req=1, no ack yet), set drop flag: keep mem_req/mem_addr until ack,
//   discard that data, clear the flag, then request redirect_pc.
//   A second redirect while dropping overwrites the target PC; only one drop occurs.
//   Redirect during VEC_LO/VEC_HI is ignored.
//  Reset mid-operation: immediate return to reset state. The memory side must tolerate an abandoned request.
// TESTING
//  T1 reset, vector mem[FFFC]=00,[FFFD]=04 -> first opcode request at addr 0400;
//     inst_pc=0400 on first bundle.
//  T2 zero-wait mem, bytes A9 05 8D 00 02 EA, inst_ready=1 ->
//     bundles (A9,05,--,len2), (8D,00,02,len3), (EA,len1); op bytes of short insts are 0.
//  T3 inst_ready held 0 for 5 cycles in HOLD -> bundle stable, no mem_req; release -> next OPC fetch.
//  T4 mem_ack delayed 3 cycles each byte -> mem_addr stable during wait; correct bundles, no dup/skip.
//  T5 redirect_pc=1234 while OP1 request waits for ack -> ack data discarded;
//     next request addr 1234; no stale bundle.
//  T6 pc=FFFF opcode 4C (len3) -> operand reads at 0000,0001; next opcode fetch at 0002.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front end: reads opcode/operand bytes from a byte-wide memory,
// pre-decodes the 6502 instruction length and hands one bundle per handshake to the decoder.
module inst_fetch #(
  parameter logic [15:0] VEC_ADDR   = 16'hFFFC,
  parameter bit          USE_VECTOR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [7:0]  inst_opcode,
  output logic [7:0]  inst_op1,
  output logic [7:0]  inst_op2,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc
);

  typedef enum logic [2:0] {
    S_VEC_LO,
    S_VEC_HI,
    S_OPC,
    S_OP1,
    S_OP2,
    S_HOLD
  } state_e;

  localparam logic [15:0] VEC_HI_ADDR = VEC_ADDR + 16'd1;

  state_e      state_q;
  logic [15:0] pc_q;
  logic        drop_q;
  logic        mem_req_q;
  logic [15:0] mem_addr_q;
  logic        inst_valid_q;
  logic [7:0]  opcode_q;
  logic [7:0]  op1_q;
  logic [7:0]  op2_q;
  logic [1:0]  len_q;
  logic [15:0] inst_pc_q;

  logic [15:0] pc_inc_d;
  logic [1:0]  len_d;
  logic        in_vector_d;

  // 6502 length decode; ordered checks mirror the irregular corners of the opcode map.
  function automatic logic [1:0] predecode_len(input logic [7:0] o);
    logic [1:0] cc;
    logic [2:0] bbb;
    cc  = o[1:0];
    bbb = o[4:2];
    if (o == 8'h20)                                  return 2'd3;
    if (o == 8'h00 || o == 8'h40 || o == 8'h60)      return 2'd1;
    if (o[4:0] == 5'b10000)                          return 2'd2;
    if (o[3:0] == 4'b1000)                           return 2'd1;
    if (o[7] && o[3:0] == 4'b1010)                   return 2'd1;
    case (cc)
      2'b01: return (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
      2'b11: return 2'd1;
      default: begin
        case (bbb)
          3'b000, 3'b001, 3'b101: return 2'd2;
          3'b011, 3'b111:         return 2'd3;
          default:                return 2'd1;
        endcase
      end
    endcase
  endfunction

  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    pc_inc_d    = pc_q + 16'd1;
    len_d       = predecode_len(mem_rdata);
    in_vector_d = (state_q == S_VEC_LO) || (state_q == S_VEC_HI);
  end

  // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is only seen on a rising edge.
    if (!rst_n) begin
      state_q      <= USE_VECTOR ? S_VEC_LO : S_OPC;
      pc_q         <= VEC_ADDR;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 16'h0000;
      inst_valid_q <= 1'b0;
      opcode_q     <= 8'h00;
      op1_q        <= 8'h00;
      op2_q        <= 8'h00;
      len_q        <= 2'd0;
      inst_pc_q    <= 16'h0000;
    end else if (redirect_valid && !in_vector_d) begin
      state_q      <= S_OPC;
      pc_q         <= redirect_pc;
      inst_valid_q <= 1'b0;
      // An unacknowledged read must finish on the bus; its data is thrown away later.
      if (mem_req_q && !mem_ack) begin
        drop_q <= 1'b1;
      end else begin
        drop_q     <= 1'b0;
        mem_req_q  <= 1'b1;
        mem_addr_q <= redirect_pc;
      end
    end else if (drop_q) begin
      if (mem_ack) begin
        drop_q     <= 1'b0;
        mem_addr_q <= pc_q;
      end
    end else begin
      case (state_q)
        S_VEC_LO: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= VEC_ADDR;
          end else if (mem_ack) begin
            pc_q[7:0]  <= mem_rdata;
            mem_addr_q <= VEC_HI_ADDR;
            state_q    <= S_VEC_HI;
          end
        end
        S_VEC_HI: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= VEC_HI_ADDR;
          end else if (mem_ack) begin
            pc_q       <= {mem_rdata, pc_q[7:0]};
            mem_addr_q <= {mem_rdata, pc_q[7:0]};
            state_q    <= S_OPC;
          end
        end
        S_OPC: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end else if (mem_ack) begin
            opcode_q  <= mem_rdata;
            op1_q     <= 8'h00;
            op2_q     <= 8'h00;
            len_q     <= len_d;
            inst_pc_q <= pc_q;
            pc_q      <= pc_inc_d;
            if (len_d == 2'd1) begin
              mem_req_q    <= 1'b0;
              inst_valid_q <= 1'b1;
              state_q      <= S_HOLD;
            end else begin
              mem_addr_q <= pc_inc_d;
              state_q    <= S_OP1;
            end
          end
        end
        S_OP1: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end else if (mem_ack) begin
            op1_q <= mem_rdata;
            pc_q  <= pc_inc_d;
            if (len_q == 2'd3) begin
              mem_addr_q <= pc_inc_d;
              state_q    <= S_OP2;
            end else begin
              mem_req_q    <= 1'b0;
              inst_valid_q <= 1'b1;
              state_q      <= S_HOLD;
            end
          end
        end
        S_OP2: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end else if (mem_ack) begin
            op2_q        <= mem_rdata;
            pc_q         <= pc_inc_d;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= pc_q;
            state_q      <= S_OPC;
          end
        end
        default: state_q <= S_OPC;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign inst_valid  = inst_valid_q;
  assign inst_opcode = opcode_q;
  assign inst_op1    = op1_q;
  assign inst_op2    = op2_q;
  assign inst_len    = len_q;
  assign inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model with programmable wait states,
// scoreboard of expected bundles and a log of acknowledged read addresses.
module tb_inst_fetch;

  typedef struct packed {
    logic [7:0]  opc;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
    logic [15:0] pc;
  } bundle_t;

  typedef struct {
    logic [7:0] opc;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [1:0] len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_opcode;
  logic [7:0]  inst_op1;
  logic [7:0]  inst_op2;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;

  int n_checks = 0;
  int n_errors = 0;

  bundle_t     sb[$];
  logic [15:0] ack_log[$];
  logic [7:0]  mem [0:65535];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  bundle_t     dut_b;
  logic [15:0] prog_end;

  // Unused operand fields are 0 so the expected bundle can be built straight from the row.
  vec_t vecs [22] = '{
    '{8'hA9, 8'h05, 8'h00, 2'd2}, '{8'h8D, 8'h00, 8'h02, 2'd3}, '{8'hEA, 8'h00, 8'h00, 2'd1},
    '{8'h20, 8'h11, 8'h22, 2'd3}, '{8'h00, 8'h00, 8'h00, 2'd1}, '{8'h40, 8'h00, 8'h00, 2'd1},
    '{8'h60, 8'h00, 8'h00, 2'd1}, '{8'h10, 8'hF0, 8'h00, 2'd2}, '{8'h18, 8'h00, 8'h00, 2'd1},
    '{8'h8A, 8'h00, 8'h00, 2'd1}, '{8'hAD, 8'h34, 8'h12, 2'd3}, '{8'hB1, 8'h80, 8'h00, 2'd2},
    '{8'h0A, 8'h00, 8'h00, 2'd1}, '{8'h0E, 8'h00, 8'h03, 2'd3}, '{8'h03, 8'h00, 8'h00, 2'd1},
    '{8'h1D, 8'h10, 8'h20, 2'd3}, '{8'h19, 8'h30, 8'h40, 2'd3}, '{8'hA2, 8'hFF, 8'h00, 2'd2},
    '{8'h96, 8'h44, 8'h00, 2'd2}, '{8'h24, 8'h55, 8'h00, 2'd2}, '{8'h2C, 8'h66, 8'h77, 2'd3},
    '{8'h4C, 8'h78, 8'h56, 2'd3}
  };

  inst_fetch #(.VEC_ADDR(16'hFFFC), .USE_VECTOR(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_opcode    (inst_opcode),
    .inst_op1       (inst_op1),
    .inst_op2       (inst_op2),
    .inst_len       (inst_len),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem[mem_addr];
  assign dut_b     = {inst_opcode, inst_op1, inst_op2, inst_len, inst_pc};

  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

  function automatic bundle_t mk(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] l, input logic [15:0] p);
    mk = {o, a, b, l, p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: request hold rules, ack log, and scoreboard compare on each accepted bundle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait <= 1'b0;
    end else begin
      if (prev_wait) begin
        check("req_held_until_ack", mem_req, 1'b1);
        check("addr_stable_in_wait", mem_addr, prev_addr);
      end
      if (mem_req && mem_ack) ack_log.push_back(mem_addr);
      if (inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL bundle_unexpected: got %h expected none", dut_b);
        end else begin
          check("bundle", dut_b, sb.pop_front());
        end
      end
      prev_wait <= mem_req && !mem_ack;
      prev_addr <= mem_addr;
    end
  end

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
    @(posedge clk);
    #1 inst_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", inst_valid, 1'b1);
  endtask

  task automatic wait_req_addr(input logic [15:0] a, input int budget);
    int n = 0;
    while (!(mem_req && mem_addr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("req_addr", mem_addr, a);
  endtask

  task automatic do_redirect(input logic [15:0] p);
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = p;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [15:0] exp);
    logic [63:0] a;
    if (idx < ack_log.size()) a = {48'd0, ack_log[idx]};
    else a = 'x;
    check(name, a, {48'd0, exp});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h04;

    prog_end = 16'h0400;
    for (int i = 0; i < 22; i++) begin
      mem[prog_end] = vecs[i].opc;
      if (vecs[i].len >= 2'd2) mem[prog_end + 16'd1] = vecs[i].b1;
      if (vecs[i].len == 2'd3) mem[prog_end + 16'd2] = vecs[i].b2;
      sb.push_back(mk(vecs[i].opc, vecs[i].b1, vecs[i].b2, vecs[i].len, prog_end));
      prog_end = prog_end + {14'd0, vecs[i].len};
    end

    // Reset state, vector fetch, then the length table at zero wait
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {mem_req, mem_addr, inst_valid, dut_b}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    inst_ready = 1'b1;
    wait_sb_empty(400);
    check_log("vec_lo_addr", 0, 16'hFFFC);
    check_log("vec_hi_addr", 1, 16'hFFFD);
    check_log("first_opc_addr", 2, 16'h0400);

    // Back-pressure: bundle held stable with no request, then released
    wait_valid(50);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", inst_valid, 1'b1);
      check("hold_no_req", mem_req, 1'b0);
      check("hold_bundle", dut_b, mk(8'h00, 8'h00, 8'h00, 2'd1, prog_end));
    end
    sb.push_back(mk(8'h00, 8'h00, 8'h00, 2'd1, prog_end));
    @(posedge clk);
    #1 inst_ready = 1'b1;
    @(posedge clk);
    #1 inst_ready = 1'b0;
    wait_req_addr(prog_end + 16'd1, 20);
    check("hold_release_popped", sb.size(), 0);
    wait_valid(20);

    // Three wait states per byte
    ack_delay = 3;
    mem[16'h0600] = 8'hA9; mem[16'h0601] = 8'h05; mem[16'h0602] = 8'h8D;
    mem[16'h0603] = 8'h00; mem[16'h0604] = 8'h02; mem[16'h0605] = 8'hEA;
    sb.push_back(mk(8'hA9, 8'h05, 8'h00, 2'd2, 16'h0600));
    sb.push_back(mk(8'h8D, 8'h00, 8'h02, 2'd3, 16'h0602));
    sb.push_back(mk(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0605));
    do_redirect(16'h0600);
    inst_ready = 1'b1;
    wait_sb_empty(300);
    wait_valid(50);

    // Redirect, then a second redirect, while the OP1 read is still waiting
    ack_log.delete();
    mem[16'h0700] = 8'hA9; mem[16'h0701] = 8'h77;
    mem[16'h2000] = 8'hA9; mem[16'h2001] = 8'h55;
    mem[16'h1234] = 8'hEA;
    sb.push_back(mk(8'hEA, 8'h00, 8'h00, 2'd1, 16'h1234));
    do_redirect(16'h0700);
    inst_ready = 1'b1;
    wait_req_addr(16'h0701, 30);
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 16'h2000;
    @(posedge clk);
    #1 redirect_pc = 16'h1234;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    wait_sb_empty(100);
    check_log("redir_first", 0, 16'h0700);
    check_log("redir_dropped", 1, 16'h0701);
    check_log("redir_target", 2, 16'h1234);
    wait_valid(50);

    // PC wrap from FFFF
    ack_delay = 0;
    ack_log.delete();
    mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'hEA;
    sb.push_back(mk(8'h4C, 8'h34, 8'h12, 2'd3, 16'hFFFF));
    sb.push_back(mk(8'hEA, 8'h00, 8'h00, 2'd1, 16'h0002));
    do_redirect(16'hFFFF);
    inst_ready = 1'b1;
    wait_sb_empty(100);
    check_log("wrap_opc", 0, 16'hFFFF);
    check_log("wrap_op1", 1, 16'h0000);
    check_log("wrap_op2", 2, 16'h0001);
    check_log("wrap_next", 3, 16'h0002);
    wait_valid(20);

    // Reset during an outstanding read, then redirects ignored during vector fetch
    ack_delay = 3;
    do_redirect(16'h0400);
    wait_req_addr(16'h0400, 10);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midop_reset_outputs", {mem_req, mem_addr, inst_valid, dut_b}, 64'd0);
    ack_delay = 2;
    redirect_valid = 1'b1;
    redirect_pc = 16'h3000;
    sb.push_back(mk(8'hA9, 8'h05, 8'h00, 2'd2, 16'h0400));
    @(posedge clk);
    #1 ack_log.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 redirect_valid = 1'b0;
    wait_sb_empty(100);
    check_log("rst2_vec_lo", 0, 16'hFFFC);
    check_log("rst2_vec_hi", 1, 16'hFFFD);
    check_log("rst2_opc", 2, 16'h0400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
